// File: rtl/counter8b_up_down.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : counter8b_up_down                                                |
// | Desc    : WIDTH-bit up/down counter with async reset, load, enable and tc. |
// |           Define COUNTER8B_SATURATE_EN to saturate instead of wrapping.    |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module counter8b_up_down #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             dir_i,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tc_o
);

  localparam logic [WIDTH-1:0] C_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             at_max;
  logic             at_min;

  assign at_max = &count_q;
  assign at_min = ~|count_q;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i) begin
`ifdef COUNTER8B_SATURATE_EN
      if (dir_i) begin
        if (!at_max) count_d = count_q + C_ONE;
      end else begin
        if (!at_min) count_d = count_q - C_ONE;
      end
`else
      // Natural WIDTH-bit truncation gives the modulo wrap in both directions.
      count_d = dir_i ? (count_q + C_ONE) : (count_q - C_ONE);
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign tc_o    = dir_i ? at_max : at_min;

endmodule
`default_nettype wire

// File: tb/tb_counter8b_up_down.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_counter8b_up_down                                             |
// | Desc    : Directed, table-driven bench for counter8b_up_down.              |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_counter8b_up_down;

  logic       clk;
  logic       rst_n;
  logic       dir;
  logic       en;
  logic       load;
  logic [7:0] load_val;
  logic [7:0] count;
  logic       tc;

  int n_cmp = 0;
  int n_err = 0;

  counter8b_up_down #(.WIDTH(8)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .dir_i      (dir),
    .en_i       (en),
    .load_i     (load),
    .load_val_i (load_val),
    .count_o    (count),
    .tc_o       (tc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       load;
    logic       en;
    logic       dir;
    logic [7:0] load_val;
    logic [7:0] exp_count;
    logic       exp_tc;
  } vec_t;

  localparam int NVEC = 16;
  vec_t vec [NVEC];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
`ifdef COUNTER8B_SATURATE_EN
    localparam logic [7:0] UP_FF = 8'hFF;
    localparam logic       UP_TC = 1'b1;
    localparam logic [7:0] DN_00 = 8'h00;
    localparam logic       DN_TC = 1'b1;
`else
    localparam logic [7:0] UP_FF = 8'h00;
    localparam logic       UP_TC = 1'b0;
    localparam logic [7:0] DN_00 = 8'hFF;
    localparam logic       DN_TC = 1'b0;
`endif
    //             load  en    dir   val    count  tc
    vec[0]  = '{1'b1, 1'b0, 1'b1, 8'hFE, 8'hFE, 1'b0};
    vec[1]  = '{1'b0, 1'b1, 1'b1, 8'h00, 8'hFF, 1'b1};
    vec[2]  = '{1'b0, 1'b1, 1'b1, 8'h00, UP_FF, UP_TC};
    vec[3]  = '{1'b0, 1'b1, 1'b1, 8'h00, (UP_FF == 8'hFF) ? 8'hFF : 8'h01, UP_TC};
    vec[4]  = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1};
    vec[5]  = '{1'b0, 1'b1, 1'b0, 8'h00, DN_00, DN_TC};
    vec[6]  = '{1'b1, 1'b1, 1'b1, 8'h37, 8'h37, 1'b0};
    vec[7]  = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h37, 1'b0};
    vec[8]  = '{1'b0, 1'b0, 1'b1, 8'hAA, 8'h37, 1'b0};
    vec[9]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h37, 1'b0};
    vec[10] = '{1'b0, 1'b0, 1'b0, 8'h11, 8'h37, 1'b0};
    vec[11] = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h37, 1'b0};
    vec[12] = '{1'b1, 1'b1, 1'b1, 8'h5A, 8'h5A, 1'b0};
    vec[13] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h59, 1'b0};
    vec[14] = '{1'b1, 1'b1, 1'b0, 8'h01, 8'h01, 1'b0};
    vec[15] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1};

    rst_n = 1'b0; dir = 1'b0; en = 1'b0; load = 1'b0; load_val = 8'h00;
    #12;
    chk("reset_count", count, 8'h00);
    chk("reset_tc_down", {7'd0, tc}, 8'h01);
    dir = 1'b1;
    #1;
    chk("reset_tc_up", {7'd0, tc}, 8'h00);
    tick();
    chk("reset_hold", count, 8'h00);

    rst_n = 1'b1; en = 1'b1; dir = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      tick();
      chk("count_up", count, 8'(i));
    end
    chk("up_tc", {7'd0, tc}, 8'h00);

    dir = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      tick();
      chk("count_down", count, 8'(100 - i));
    end
    chk("down_tc_at_zero", {7'd0, tc}, 8'h01);
    dir = 1'b1;
    #1;
    chk("tc_dir_flip", {7'd0, tc}, 8'h00);

    for (int i = 0; i < NVEC; i++) begin
      load = vec[i].load; en = vec[i].en; dir = vec[i].dir; load_val = vec[i].load_val;
      tick();
      chk($sformatf("vec%0d_count", i), count, vec[i].exp_count);
      chk($sformatf("vec%0d_tc", i), {7'd0, tc}, {7'd0, vec[i].exp_tc});
    end

    load = 1'b1; en = 1'b1; dir = 1'b1; load_val = 8'h77;
    tick();
    chk("preload", count, 8'h77);
    load_val = 8'h33;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_during_load", count, 8'h00);
    tick();
    chk("reset_beats_load", count, 8'h00);
    rst_n = 1'b1; load = 1'b0; en = 1'b1; dir = 1'b1;
    tick();
    chk("resume_after_reset", count, 8'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
